// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage -- data-memory handshake, stall, branch resolve, MEM/WB register
//   clk, rst            : clock; synchronous active-high reset
//   *_in                : EX/MEM register fields (control bits, pc, ALU result, store data, dest reg)
//   dmem_req/we/addr/wdata, dmem_ack/rdata : data-memory request and completion
//   stall               : holds the upstream pipeline while an access is outstanding
//   PCSrc, branch_target: branch redirect to fetch
//   *_out               : MEM/WB register fields
//   mem_err             : sticky watchdog timeout flag (only when MEM_TIMEOUT_EN is defined)
//   MEM_TIMEOUT_EN      : define to build the WAIT-state watchdog (TIMEOUT_CYC cycles)
module mem_stage #(
   parameter int TIMEOUT_CYC = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWrite_in,
   input  logic        MemtoReg_in,
   input  logic        MemWrite_in,
   input  logic        MemRead_in,
   input  logic        Branch_in,
   input  logic        Zero_in,
   input  logic [31:0] pc_in,
   input  logic [31:0] ALU_in,
   input  logic [31:0] WD_in,
   input  logic [4:0]  WN_in,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        PCSrc,
   output logic [31:0] branch_target,
`ifdef MEM_TIMEOUT_EN
   output logic        mem_err,
`endif
   output logic        RegWrite_out,
   output logic        MemtoReg_out,
   output logic [31:0] RD_out,
   output logic [31:0] ALU_out,
   output logic [4:0]  WN_out
);
   typedef enum logic {IDLE, WAIT} state_t;
   state_t r_state, w_next;
   logic w_access, w_to, w_rd;
   assign w_access = MemRead_in | MemWrite_in;
`ifdef MEM_TIMEOUT_EN
   logic [31:0] r_cnt;
   logic        r_err;
   // r_cnt is 0 in the first WAIT cycle, so the watchdog fires on WAIT cycle TIMEOUT_CYC
   assign w_to = (r_state == WAIT) && !dmem_ack && (r_cnt == 32'(TIMEOUT_CYC - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_err <= 1'b0;
      end else begin
         r_cnt <= (r_state == WAIT && !dmem_ack && !w_to) ? r_cnt + 32'd1 : '0;
         r_err <= r_err | w_to;
      end
   end
   assign mem_err = r_err;
`else
   assign w_to = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end
   always_comb begin
      dmem_req = (r_state == WAIT) | w_access;
      w_next   = (r_state == IDLE) ? ((w_access & ~dmem_ack) ? WAIT : IDLE)
                                   : ((dmem_ack | w_to) ? IDLE : WAIT);
   end
   assign dmem_we       = MemWrite_in;
   assign dmem_addr     = {ALU_in[31:2], 2'b00};
   assign dmem_wdata    = WD_in;
   // a forced (timed-out) completion counts as "not stalled" but never returns load data
   assign stall         = dmem_req & ~dmem_ack & ~w_to;
   // read+write together is treated as a write, so no load data is captured
   assign w_rd          = dmem_req & dmem_ack & MemRead_in & ~MemWrite_in;
   assign PCSrc         = Branch_in & Zero_in & ~stall;
   assign branch_target = pc_in;
   always_ff @(posedge clk) begin
      if (rst || stall) begin
         RegWrite_out <= 1'b0;
         MemtoReg_out <= 1'b0;
         RD_out       <= '0;
         ALU_out      <= '0;
         WN_out       <= '0;
      end else begin
         RegWrite_out <= RegWrite_in;
         MemtoReg_out <= MemtoReg_in;
         RD_out       <= w_rd ? dmem_rdata : '0;
         ALU_out      <= ALU_in;
         WN_out       <= WN_in;
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic        RegWrite_in, MemtoReg_in, MemWrite_in, MemRead_in, Branch_in, Zero_in;
   logic [31:0] pc_in, ALU_in, WD_in;
   logic [4:0]  WN_in;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        stall, PCSrc;
   logic [31:0] branch_target;
   logic        RegWrite_out, MemtoReg_out;
   logic [31:0] RD_out, ALU_out;
   logic [4:0]  WN_out;
`ifdef MEM_TIMEOUT_EN
   logic        mem_err;
`endif
   int vecs = 0;
   int errs = 0;

   mem_stage #(.TIMEOUT_CYC(16)) dut (
      .clk(clk), .rst(rst),
      .RegWrite_in(RegWrite_in), .MemtoReg_in(MemtoReg_in), .MemWrite_in(MemWrite_in),
      .MemRead_in(MemRead_in), .Branch_in(Branch_in), .Zero_in(Zero_in),
      .pc_in(pc_in), .ALU_in(ALU_in), .WD_in(WD_in), .WN_in(WN_in),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
`ifdef MEM_TIMEOUT_EN
      .mem_err(mem_err),
`endif
      .RegWrite_out(RegWrite_out), .MemtoReg_out(MemtoReg_out),
      .RD_out(RD_out), .ALU_out(ALU_out), .WN_out(WN_out)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs;
      RegWrite_in = 0; MemtoReg_in = 0; MemWrite_in = 0; MemRead_in = 0;
      Branch_in = 0; Zero_in = 0; pc_in = 0; ALU_in = 0; WD_in = 0; WN_in = 0;
      dmem_ack = 0; dmem_rdata = 0;
   endtask

   task automatic test_reset;
      clear_inputs();
      rst = 1;
      RegWrite_in = 1; MemtoReg_in = 1; ALU_in = 32'h9; WN_in = 5'd3;
      tick();
      tick();
      vecs++; if (RegWrite_out !== 1'b0) begin errs++; $display("FAIL rst_regwrite got=%h exp=0", RegWrite_out); end
      vecs++; if (MemtoReg_out !== 1'b0) begin errs++; $display("FAIL rst_memtoreg got=%h exp=0", MemtoReg_out); end
      vecs++; if (ALU_out !== 32'h0) begin errs++; $display("FAIL rst_alu got=%h exp=0", ALU_out); end
      vecs++; if (WN_out !== 5'h0) begin errs++; $display("FAIL rst_wn got=%h exp=0", WN_out); end
      vecs++; if (RD_out !== 32'h0) begin errs++; $display("FAIL rst_rd got=%h exp=0", RD_out); end
      clear_inputs();
      rst = 0;
      #1;
      vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL rst_req got=%h exp=0", dmem_req); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL rst_stall got=%h exp=0", stall); end
   endtask

   task automatic test_zero_wait_load;
      clear_inputs();
      MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; ALU_in = 32'h100; WN_in = 5'd5;
      dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
      #1;
      vecs++; if (dmem_req !== 1'b1) begin errs++; $display("FAIL zw_req got=%h exp=1", dmem_req); end
      vecs++; if (dmem_we !== 1'b0) begin errs++; $display("FAIL zw_we got=%h exp=0", dmem_we); end
      vecs++; if (dmem_addr !== 32'h100) begin errs++; $display("FAIL zw_addr got=%h exp=100", dmem_addr); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL zw_stall got=%h exp=0", stall); end
      tick();
      clear_inputs();
      vecs++; if (RD_out !== 32'hDEADBEEF) begin errs++; $display("FAIL zw_rd got=%h exp=deadbeef", RD_out); end
      vecs++; if (WN_out !== 5'd5) begin errs++; $display("FAIL zw_wn got=%h exp=05", WN_out); end
      vecs++; if (RegWrite_out !== 1'b1) begin errs++; $display("FAIL zw_regwrite got=%h exp=1", RegWrite_out); end
      vecs++; if (MemtoReg_out !== 1'b1) begin errs++; $display("FAIL zw_memtoreg got=%h exp=1", MemtoReg_out); end
      vecs++; if (ALU_out !== 32'h100) begin errs++; $display("FAIL zw_alu got=%h exp=100", ALU_out); end
      #1;
      vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL zw_reissue got=%h exp=0", dmem_req); end
      tick();
   endtask

   task automatic test_store_wait;
      int reqs = 0;
      clear_inputs();
      MemWrite_in = 1; RegWrite_in = 1; WD_in = 32'h12345678; ALU_in = 32'h103; WN_in = 5'd9;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (dmem_req && dmem_we) reqs++;
         vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL st_stall%0d got=%h exp=1", i, stall); end
         vecs++; if (dmem_addr !== 32'h100) begin errs++; $display("FAIL st_addr%0d got=%h exp=100", i, dmem_addr); end
         vecs++; if (dmem_wdata !== 32'h12345678) begin errs++; $display("FAIL st_wdata%0d got=%h exp=12345678", i, dmem_wdata); end
         tick();
         vecs++; if (RegWrite_out !== 1'b0) begin errs++; $display("FAIL st_bubble%0d got=%h exp=0", i, RegWrite_out); end
         vecs++; if (ALU_out !== 32'h0) begin errs++; $display("FAIL st_bubble_alu%0d got=%h exp=0", i, ALU_out); end
      end
      dmem_ack = 1; dmem_rdata = 32'hAAAA5555;
      #1;
      if (dmem_req && dmem_we) reqs++;
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL st_ack_stall got=%h exp=0", stall); end
      tick();
      clear_inputs();
      vecs++; if (RegWrite_out !== 1'b1) begin errs++; $display("FAIL st_done_regwrite got=%h exp=1", RegWrite_out); end
      vecs++; if (RD_out !== 32'h0) begin errs++; $display("FAIL st_done_rd got=%h exp=0", RD_out); end
      vecs++; if (ALU_out !== 32'h103) begin errs++; $display("FAIL st_done_alu got=%h exp=103", ALU_out); end
      vecs++; if (WN_out !== 5'd9) begin errs++; $display("FAIL st_done_wn got=%h exp=09", WN_out); end
      #1;
      if (dmem_req) reqs++;
      vecs++; if (reqs !== 4) begin errs++; $display("FAIL st_req_cycles got=%0d exp=4", reqs); end
      tick();
   endtask

   task automatic test_branch;
      clear_inputs();
      Branch_in = 1; Zero_in = 1; pc_in = 32'h40;
      #1;
      vecs++; if (PCSrc !== 1'b1) begin errs++; $display("FAIL br_taken got=%h exp=1", PCSrc); end
      vecs++; if (branch_target !== 32'h40) begin errs++; $display("FAIL br_target got=%h exp=40", branch_target); end
      Zero_in = 0;
      #1;
      vecs++; if (PCSrc !== 1'b0) begin errs++; $display("FAIL br_notzero got=%h exp=0", PCSrc); end
      Zero_in = 1; MemRead_in = 1;
      #1;
      vecs++; if (PCSrc !== 1'b0) begin errs++; $display("FAIL br_stalled got=%h exp=0", PCSrc); end
      dmem_ack = 1;
      #1;
      vecs++; if (PCSrc !== 1'b1) begin errs++; $display("FAIL br_acked got=%h exp=1", PCSrc); end
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_rw_both;
      clear_inputs();
      MemRead_in = 1; MemWrite_in = 1; RegWrite_in = 1; ALU_in = 32'h44;
      dmem_ack = 1; dmem_rdata = 32'h0000FFFF;
      #1;
      vecs++; if (dmem_we !== 1'b1) begin errs++; $display("FAIL rw_we got=%h exp=1", dmem_we); end
      tick();
      clear_inputs();
      vecs++; if (RD_out !== 32'h0) begin errs++; $display("FAIL rw_rd got=%h exp=0", RD_out); end
      tick();
   endtask

   task automatic test_ack_idle;
      clear_inputs();
      RegWrite_in = 1; WN_in = 5'd7; ALU_in = 32'h5; dmem_ack = 1; dmem_rdata = 32'h11112222;
      #1;
      vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL ai_req got=%h exp=0", dmem_req); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL ai_stall got=%h exp=0", stall); end
      tick();
      vecs++; if (RD_out !== 32'h0) begin errs++; $display("FAIL ai_rd got=%h exp=0", RD_out); end
      vecs++; if (WN_out !== 5'd7) begin errs++; $display("FAIL ai_wn got=%h exp=07", WN_out); end
      dmem_ack = 0; MemRead_in = 1;
      #1;
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL ai_state got=%h exp=1", stall); end
      dmem_ack = 1;
      tick();
      clear_inputs();
      tick();
   endtask

   task automatic test_reset_mid_wait;
      clear_inputs();
      MemRead_in = 1; RegWrite_in = 1; MemtoReg_in = 1; ALU_in = 32'h200; WN_in = 5'd4;
      #1;
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL rw_idle_stall got=%h exp=1", stall); end
      tick();
      tick();
      rst = 1; dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
      tick();
      rst = 0;
      clear_inputs();
      #1;
      vecs++; if (RD_out !== 32'h0) begin errs++; $display("FAIL mr_rd got=%h exp=0", RD_out); end
      vecs++; if (RegWrite_out !== 1'b0) begin errs++; $display("FAIL mr_regwrite got=%h exp=0", RegWrite_out); end
      vecs++; if (ALU_out !== 32'h0) begin errs++; $display("FAIL mr_alu got=%h exp=0", ALU_out); end
      vecs++; if (WN_out !== 5'h0) begin errs++; $display("FAIL mr_wn got=%h exp=0", WN_out); end
      vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL mr_req got=%h exp=0", dmem_req); end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL mr_stall got=%h exp=0", stall); end
      tick();
   endtask

`ifdef MEM_TIMEOUT_EN
   task automatic test_timeout;
      clear_inputs();
      vecs++; if (mem_err !== 1'b0) begin errs++; $display("FAIL to_err_init got=%h exp=0", mem_err); end
      MemRead_in = 1; RegWrite_in = 1; ALU_in = 32'h300; dmem_rdata = 32'h77777777;
      #1;
      vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL to_idle_stall got=%h exp=1", stall); end
      tick();
      for (int i = 1; i < 16; i++) begin
         vecs++; if (stall !== 1'b1) begin errs++; $display("FAIL to_wait%0d_stall got=%h exp=1", i, stall); end
         tick();
      end
      vecs++; if (stall !== 1'b0) begin errs++; $display("FAIL to_release got=%h exp=0", stall); end
      tick();
      clear_inputs();
      vecs++; if (RD_out !== 32'h0) begin errs++; $display("FAIL to_rd got=%h exp=0", RD_out); end
      vecs++; if (RegWrite_out !== 1'b1) begin errs++; $display("FAIL to_regwrite got=%h exp=1", RegWrite_out); end
      vecs++; if (mem_err !== 1'b1) begin errs++; $display("FAIL to_err got=%h exp=1", mem_err); end
      tick();
      tick();
      vecs++; if (mem_err !== 1'b1) begin errs++; $display("FAIL to_err_sticky got=%h exp=1", mem_err); end
      vecs++; if (dmem_req !== 1'b0) begin errs++; $display("FAIL to_idle_req got=%h exp=0", dmem_req); end
      rst = 1;
      tick();
      rst = 0;
      vecs++; if (mem_err !== 1'b0) begin errs++; $display("FAIL to_err_clr got=%h exp=0", mem_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_zero_wait_load();
      test_store_wait();
      test_branch();
      test_rw_both();
      test_ack_idle();
      test_reset_mid_wait();
`ifdef MEM_TIMEOUT_EN
      test_timeout();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
